// File: rtl/sensor_request_controller.sv
// Request dispatcher between the UART pair and NUM_SENSORS sensor channels.
// Optional continuous monitoring is built when CONT_MONITOR_EN is defined.
module sensor_request_controller #(
    parameter int NUM_SENSORS    = 32,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int PERIOD_CYCLES  = 100_000_000
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       rx_valid_i,
    input  logic [7:0]                 rx_command_i,
    input  logic [7:0]                 rx_address_i,
    output logic [NUM_SENSORS-1:0]     sens_start_o,
    input  logic [NUM_SENSORS-1:0]     sens_done_i,
    input  logic [NUM_SENSORS-1:0]     sens_error_i,
    input  logic [16*NUM_SENSORS-1:0]  sens_data_i,
    output logic                       tx_start_o,
    output logic [7:0]                 tx_code_o,
    output logic [7:0]                 tx_value_o,
    input  logic                       tx_done_i,
    output logic                       busy_o,
    output logic                       overrun_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_START, S_WAIT, S_LOAD, S_SEND, S_WAITTX
    } state_t;

    state_t state_q, state_d;
    logic [7:0] cmd_q, cmd_d, addr_q, addr_d;
    logic [7:0] bcmd_q, bcmd_d, baddr_q, baddr_d;
    logic bvld_q, bvld_d, ovr_q, ovr_d;
    logic [7:0] code_q, code_d, val_q, val_d;
    logic [TW-1:0] tmo_q, tmo_d;
`ifdef CONT_MONITOR_EN
    localparam int PW = $clog2(PERIOD_CYCLES);
    logic cont_t_q, cont_t_d, cont_h_q, cont_h_d;
    logic due_t_q, due_t_d, due_h_q, due_h_d;
    logic [7:0] caddr_q, caddr_d;
    logic [PW-1:0] per_q, per_d;
`endif

    logic sel_done, sel_err, addr_bad, cmd_ok;
    logic [15:0] sel_data;

    // Per-channel select of the addressed sensor's handshake and outputs
    always_comb begin
        sel_done = 1'b0;
        sel_err = 1'b0;
        sel_data = 16'h0000;
        sens_start_o = '0;
        for (int k = 0; k < NUM_SENSORS; k++) begin
            if (addr_q == 8'(k + 1)) begin
                sel_done = sens_done_i[k];
                sel_err = sens_error_i[k];
                sel_data = sens_data_i[16*k +: 16];
                sens_start_o[k] = (state_q == S_START);
            end
        end
    end

    assign addr_bad = (addr_q == 8'd0) || ({1'b0, addr_q} > 9'(NUM_SENSORS));
`ifdef CONT_MONITOR_EN
    assign cmd_ok = (cmd_q <= 8'h06);
`else
    assign cmd_ok = (cmd_q <= 8'h02);
`endif
    assign busy_o = (state_q != S_IDLE);
    assign tx_start_o = (state_q == S_SEND);
    assign tx_code_o = code_q;
    assign tx_value_o = val_q;
    assign overrun_o = ovr_q;

    // Next-state logic: source select, decode, sensor handshake, response
    always_comb begin
        state_d = state_q;
        cmd_d = cmd_q;
        addr_d = addr_q;
        bcmd_d = bcmd_q;
        baddr_d = baddr_q;
        bvld_d = bvld_q;
        ovr_d = ovr_q;
        code_d = code_q;
        val_d = val_q;
        tmo_d = tmo_q;
`ifdef CONT_MONITOR_EN
        cont_t_d = cont_t_q;
        cont_h_d = cont_h_q;
        due_t_d = due_t_q;
        due_h_d = due_h_q;
        caddr_d = caddr_q;
        per_d = per_q;
        if (cont_t_q || cont_h_q) begin
            if (per_q == PW'(PERIOD_CYCLES - 1)) begin
                per_d = '0;
                due_t_d = due_t_q | cont_t_q;
                due_h_d = due_h_q | cont_h_q;
            end else begin
                per_d = per_q + 1'b1;
            end
        end else begin
            per_d = '0;
        end
`endif
        if (rx_valid_i && busy_o) begin
            if (!bvld_q) begin
                bvld_d = 1'b1;
                bcmd_d = rx_command_i;
                baddr_d = rx_address_i;
            end else begin
                ovr_d = 1'b1;
            end
        end
        unique case (state_q)
            S_IDLE: begin
                if (bvld_q) begin
                    cmd_d = bcmd_q;
                    addr_d = baddr_q;
                    bvld_d = 1'b0;
                    if (rx_valid_i) begin
                        bvld_d = 1'b1;
                        bcmd_d = rx_command_i;
                        baddr_d = rx_address_i;
                    end
                    state_d = S_DECODE;
                end else if (rx_valid_i) begin
                    cmd_d = rx_command_i;
                    addr_d = rx_address_i;
                    state_d = S_DECODE;
`ifdef CONT_MONITOR_EN
                end else if (due_t_q) begin
                    cmd_d = 8'h01;
                    addr_d = caddr_q;
                    due_t_d = 1'b0;
                    state_d = S_DECODE;
                end else if (due_h_q) begin
                    cmd_d = 8'h02;
                    addr_d = caddr_q;
                    due_h_d = 1'b0;
                    state_d = S_DECODE;
`endif
                end
            end
            S_DECODE: begin
                state_d = S_LOAD;
                if (addr_bad) begin
                    code_d = 8'hEF;
                    val_d = addr_q;
                end else if (!cmd_ok) begin
                    code_d = 8'hCF;
                    val_d = cmd_q;
`ifdef CONT_MONITOR_EN
                end else if (cmd_q == 8'h05) begin
                    cont_t_d = 1'b0;
                    due_t_d = 1'b0;
                    code_d = 8'h0A;
                    val_d = 8'h00;
                end else if (cmd_q == 8'h06) begin
                    cont_h_d = 1'b0;
                    due_h_d = 1'b0;
                    code_d = 8'h0B;
                    val_d = 8'h00;
`endif
                end else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                tmo_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sel_done) begin
                    state_d = S_LOAD;
                    if (sel_err) begin
                        code_d = 8'h1F;
                        val_d = 8'h00;
                    end else if (cmd_q == 8'h00) begin
                        code_d = 8'h00;
                        val_d = 8'h00;
                    end else if (cmd_q == 8'h01 || cmd_q == 8'h03) begin
                        code_d = 8'h09;
                        val_d = sel_data[7:0];
                    end else begin
                        code_d = 8'h08;
                        val_d = sel_data[15:8];
                    end
`ifdef CONT_MONITOR_EN
                    if (!sel_err && cmd_q == 8'h03) begin
                        cont_t_d = 1'b1;
                        caddr_d = addr_q;
                        per_d = '0;
                    end
                    if (!sel_err && cmd_q == 8'h04) begin
                        cont_h_d = 1'b1;
                        caddr_d = addr_q;
                        per_d = '0;
                    end
`endif
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    code_d = 8'h1F;
                    val_d = 8'h00;
                    state_d = S_LOAD;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_LOAD: state_d = S_SEND;
            S_SEND: state_d = S_WAITTX;
            S_WAITTX: if (tx_done_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cmd_q <= '0;
            addr_q <= '0;
            bcmd_q <= '0;
            baddr_q <= '0;
            bvld_q <= 1'b0;
            ovr_q <= 1'b0;
            code_q <= '0;
            val_q <= '0;
            tmo_q <= '0;
`ifdef CONT_MONITOR_EN
            cont_t_q <= 1'b0;
            cont_h_q <= 1'b0;
            due_t_q <= 1'b0;
            due_h_q <= 1'b0;
            caddr_q <= '0;
            per_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cmd_q <= cmd_d;
            addr_q <= addr_d;
            bcmd_q <= bcmd_d;
            baddr_q <= baddr_d;
            bvld_q <= bvld_d;
            ovr_q <= ovr_d;
            code_q <= code_d;
            val_q <= val_d;
            tmo_q <= tmo_d;
`ifdef CONT_MONITOR_EN
            cont_t_q <= cont_t_d;
            cont_h_q <= cont_h_d;
            due_t_q <= due_t_d;
            due_h_q <= due_h_d;
            caddr_q <= caddr_d;
            per_q <= per_d;
`endif
        end
    end
endmodule

// File: tb/tb_sensor_request_controller.sv
// Directed bench for sensor_request_controller.
// Small timeout/period values keep the run short.
module tb_sensor_request_controller;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst;
    logic rx_valid;
    logic [7:0] rx_cmd, rx_addr;
    logic [NS-1:0] sens_start, sens_done, sens_error;
    logic [16*NS-1:0] sens_data;
    logic tx_start, tx_done, busy, overrun;
    logic [7:0] tx_code, tx_value;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int tx_cnt = 0;
    int cyc;
    int snap_s, snap_t;

    sensor_request_controller #(
        .NUM_SENSORS(NS), .TIMEOUT_CYCLES(100), .PERIOD_CYCLES(200)
    ) dut (
        .clock_i(clk), .reset_i(rst), .rx_valid_i(rx_valid),
        .rx_command_i(rx_cmd), .rx_address_i(rx_addr),
        .sens_start_o(sens_start), .sens_done_i(sens_done),
        .sens_error_i(sens_error), .sens_data_i(sens_data),
        .tx_start_o(tx_start), .tx_code_o(tx_code), .tx_value_o(tx_value),
        .tx_done_i(tx_done), .busy_o(busy), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (|sens_start) start_cnt++;
        if (tx_start) tx_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [7:0] c, input logic [7:0] a);
        rx_valid = 1'b1;
        rx_cmd = c;
        rx_addr = a;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag, input logic [NS-1:0] m, input int bound);
        int n = 0;
        while (!(|sens_start) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sens_start), 32'(m));
    endtask

    task automatic pulse_done(input int ch, input logic err, input logic [15:0] d);
        sens_done[ch] = 1'b1;
        sens_error[ch] = err;
        sens_data[16*ch +: 16] = d;
        @(negedge clk);
        sens_done = '0;
        sens_error = '0;
    endtask

    task automatic wait_tx(input string tag, input logic [7:0] c, input logic [7:0] v);
        cyc = 0;
        while (!tx_start && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_start"}, 32'(tx_start), 32'd1);
        chk({tag, "_code"}, 32'(tx_code), 32'(c));
        chk({tag, "_val"}, 32'(tx_value), 32'(v));
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_cmd = '0;
        rx_addr = '0;
        sens_done = '0;
        sens_error = '0;
        sens_data = '0;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(sens_start), 32'd0);
        chk("rst_tx", 32'(tx_start), 32'd0);
        chk("rst_code", 32'(tx_code), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // temperature read with latency check
        req(8'h01, 8'h01);
        chk("lat_decode", 32'(sens_start), 32'd0);
        @(negedge clk);
        chk("lat_start", 32'(sens_start), 32'b0001);
        @(negedge clk);
        pulse_done(0, 1'b0, 16'h3719);
        wait_tx("temp", 8'h09, 8'h19);
        chk("idle_busy", 32'(busy), 32'd0);

        // bad address and bad command, no sensor access
        snap_s = start_cnt;
        req(8'h02, 8'h00);
        wait_tx("addr0", 8'hEF, 8'h00);
        req(8'h01, 8'h05);
        wait_tx("addr5", 8'hEF, 8'h05);
        req(8'h07, 8'h01);
        wait_tx("badcmd", 8'hCF, 8'h07);
        chk("nostart", 32'(start_cnt), 32'(snap_s));

        // highest address, humidity
        req(8'h02, 8'h04);
        wait_start("start4", 4'b1000, 10);
        @(negedge clk);
        pulse_done(3, 1'b0, 16'h4C1A);
        wait_tx("hum4", 8'h08, 8'h4C);

        // sensor error
        req(8'h01, 8'h03);
        wait_start("start3", 4'b0100, 10);
        @(negedge clk);
        pulse_done(2, 1'b1, 16'h1111);
        wait_tx("err", 8'h1F, 8'h00);

        // timeout; done on another channel is ignored
        req(8'h00, 8'h02);
        wait_start("start2", 4'b0010, 10);
        @(negedge clk);
        pulse_done(0, 1'b0, 16'h0000);
        wait_tx("tmo", 8'h1F, 8'h00);
        chk("tmo_cycles", 32'(cyc), 32'd100);

        // done in the same cycle as the timeout wins
        req(8'h00, 8'h02);
        wait_start("start2b", 4'b0010, 10);
        repeat (100) @(negedge clk);
        pulse_done(1, 1'b0, 16'h0000);
        wait_tx("tie", 8'h00, 8'h00);

        // one buffered request, one dropped
        req(8'h01, 8'h01);
        wait_start("bufA", 4'b0001, 10);
        @(negedge clk);
        req(8'h02, 8'h02);
        req(8'h07, 8'h01);
        pulse_done(0, 1'b0, 16'h2233);
        wait_tx("bufA", 8'h09, 8'h33);
        chk("ovr_set", 32'(overrun), 32'd1);
        wait_start("bufB", 4'b0010, 10);
        @(negedge clk);
        pulse_done(1, 1'b0, 16'h4422);
        wait_tx("bufB", 8'h08, 8'h44);
        snap_t = tx_cnt;
        repeat (20) @(negedge clk);
        chk("drop", 32'(tx_cnt), 32'(snap_t));
        chk("ovr_hold", 32'(overrun), 32'd1);

`ifdef CONT_MONITOR_EN
        // continuous temperature monitoring
        req(8'h03, 8'h03);
        wait_start("cont_en", 4'b0100, 10);
        @(negedge clk);
        pulse_done(2, 1'b0, 16'h5520);
        wait_tx("cont_en", 8'h09, 8'h20);
        wait_start("cont_tick", 4'b0100, 400);
        @(negedge clk);
        pulse_done(2, 1'b0, 16'h5521);
        wait_tx("cont_tick", 8'h09, 8'h21);
        req(8'h05, 8'h03);
        wait_tx("cont_dis", 8'h0A, 8'h00);
        snap_s = start_cnt;
        repeat (500) @(negedge clk);
        chk("cont_off", 32'(start_cnt), 32'(snap_s));
`else
        snap_s = start_cnt;
        req(8'h03, 8'h03);
        wait_tx("cont_na", 8'hCF, 8'h03);
        chk("cont_nostart", 32'(start_cnt), 32'(snap_s));
`endif

        // reset mid-transaction
        req(8'h01, 8'h01);
        wait_start("rstmid", 4'b0001, 10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_code", 32'(tx_code), 32'd0);
        chk("rm_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        snap_t = tx_cnt;
        pulse_done(0, 1'b0, 16'h1234);
        repeat (10) @(negedge clk);
        chk("rm_ign", 32'(tx_cnt), 32'(snap_t));
        chk("rm_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
